// File: rtl/data_bus_adapter.sv
// Memory-stage load/store responder: turns byte/half/word requests into word-aligned
// external bus transactions and returns shifted, extended load data.
module data_bus_adapter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic        mem_load,
    input  logic        mem_store,
    output logic [31:0] mem_load_data,
    output logic        mem_busy,
    input  logic        stall,
    output logic [31:0] ext_address,
    output logic [31:0] ext_write_data,
    output logic [3:0]  ext_write_strobe,
    output logic        ext_read,
    output logic        ext_write,
    input  logic        ext_ready,
    input  logic [31:0] ext_read_data,
    input  logic        ext_read_valid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        RESPONSE = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        is_load_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic [1:0]  offset_r;
    logic        accept_s;
    logic        capture_s;
    logic        dir_load_next_s;

    function automatic logic [3:0] strobe_f(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    strobe_f = 4'b0001 << off;
            2'd1:    strobe_f = 4'b0011 << {off[1], 1'b0};
            default: strobe_f = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    wdata_f = {4{d[7:0]}};
            2'd1:    wdata_f = {2{d[15:0]}};
            default: wdata_f = d;
        endcase
    endfunction

    // Halves ignore addr[0]; only byte accesses select an odd lane.
    function automatic logic [31:0] extend_f(input logic [31:0] raw, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] off);
        logic [1:0]  lane;
        logic [31:0] sh;
        lane = (size == 2'd1) ? {off[1], 1'b0} : off;
        sh   = raw >> {lane, 3'b000};
        case (size)
            2'd0:    extend_f = {{24{sgn & sh[7]}}, sh[7:0]};
            2'd1:    extend_f = {{16{sgn & sh[15]}}, sh[15:0]};
            default: extend_f = raw;
        endcase
    endfunction

    // Next-state logic plus request-accept and load-data-capture strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_load || mem_store) begin
                    accept_s     = 1'b1;
                    state_next_s = REQUEST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQUEST: begin
                if (!ext_ready) begin
                    state_next_s = REQUEST;
                end else if (!is_load_r) begin
                    state_next_s = DONE;
                end else if (ext_read_valid) begin
                    capture_s    = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RESPONSE;
                end
            end
            RESPONSE: begin
                if (ext_read_valid) begin
                    capture_s    = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RESPONSE;
                end
            end
            DONE: begin
                // Holding here while stalled keeps a still-asserted request from reissuing.
                if (!stall) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Direction the bus strobes will carry next cycle.
    always_comb begin
        if (accept_s) begin
            dir_load_next_s = mem_load;
        end else begin
            dir_load_next_s = is_load_r;
        end
    end

    // Stall request to the hazard unit; independent of the stall input.
    always_comb begin
        mem_busy = 1'b0;
        case (state_r)
            IDLE:     mem_busy = mem_load | mem_store;
            REQUEST:  mem_busy = 1'b1;
            RESPONSE: mem_busy = 1'b1;
            DONE:     mem_busy = 1'b0;
            default:  mem_busy = 1'b0;
        endcase
    end

    // State, latched request fields, registered bus outputs and load result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            is_load_r        <= 1'b0;
            size_r           <= 2'd0;
            signed_r         <= 1'b0;
            offset_r         <= 2'd0;
            ext_address      <= 32'd0;
            ext_write_data   <= 32'd0;
            ext_write_strobe <= 4'd0;
            ext_read         <= 1'b0;
            ext_write        <= 1'b0;
            mem_load_data    <= 32'd0;
        end else begin
            state_r   <= state_next_s;
            ext_read  <= (state_next_s == REQUEST) && dir_load_next_s;
            ext_write <= (state_next_s == REQUEST) && !dir_load_next_s;
            if (accept_s) begin
                is_load_r        <= mem_load;
                size_r           <= mem_size;
                signed_r         <= mem_signed;
                offset_r         <= mem_address[1:0];
                ext_address      <= {mem_address[31:2], 2'b00};
                ext_write_data   <= wdata_f(mem_size, mem_store_data);
                ext_write_strobe <= strobe_f(mem_size, mem_address[1:0]);
            end
            if (capture_s) begin
                mem_load_data <= extend_f(ext_read_data, size_r, signed_r, offset_r);
            end
        end
    end

endmodule

// File: tb/tb_data_bus_adapter.sv
// Directed self-checking bench for data_bus_adapter with a hand-driven bus.
module tb_data_bus_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_address;
    logic [31:0] mem_store_data;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_load_data;
    logic        mem_busy;
    logic        stall;
    logic [31:0] ext_address;
    logic [31:0] ext_write_data;
    logic [3:0]  ext_write_strobe;
    logic        ext_read;
    logic        ext_write;
    logic        ext_ready;
    logic [31:0] ext_read_data;
    logic        ext_read_valid;

    int checks = 0;
    int errors = 0;

    data_bus_adapter dut (
        .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_store_data(mem_store_data),
        .mem_size(mem_size), .mem_signed(mem_signed), .mem_load(mem_load), .mem_store(mem_store),
        .mem_load_data(mem_load_data), .mem_busy(mem_busy), .stall(stall),
        .ext_address(ext_address), .ext_write_data(ext_write_data),
        .ext_write_strobe(ext_write_strobe), .ext_read(ext_read), .ext_write(ext_write),
        .ext_ready(ext_ready), .ext_read_data(ext_read_data), .ext_read_valid(ext_read_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Inputs change 1 time unit after the rising edge; checks follow after a further #1.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_address = 32'd0; mem_store_data = 32'd0; mem_size = 2'd0;
        mem_signed = 1'b0; mem_load = 1'b0; mem_store = 1'b0; stall = 1'b0;
        ext_ready = 1'b0; ext_read_data = 32'd0; ext_read_valid = 1'b0;
        next_cycle(); next_cycle();
        #1;
        checks++; if (ext_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", ext_read); end
        checks++; if (ext_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", ext_write); end
        checks++; if (ext_write_strobe !== 4'd0) begin errors++; $display("FAIL reset_strobe: got %b expected 0000", ext_write_strobe); end
        checks++; if (ext_address !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ext_address); end
        checks++; if (ext_write_data !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", ext_write_data); end
        checks++; if (mem_load_data !== 32'd0) begin errors++; $display("FAIL reset_ldata: got %h expected 0", mem_load_data); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", mem_busy); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_store_byte();
        int busy_cnt = 0;
        mem_store = 1'b1; mem_address = 32'h0000_1003; mem_store_data = 32'h0000_00A5;
        mem_size = 2'd0; stall = 1'b1;
        #1;
        if (mem_busy) busy_cnt++;
        checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_n: got %b expected 1", mem_busy); end
        checks++; if (ext_write !== 1'b0) begin errors++; $display("FAIL sb_write_n: got %b expected 0", ext_write); end
        next_cycle();
        ext_ready = 1'b1;
        #1;
        if (mem_busy) busy_cnt++;
        checks++; if (ext_write !== 1'b1) begin errors++; $display("FAIL sb_write: got %b expected 1", ext_write); end
        checks++; if (ext_address !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h expected 00001000", ext_address); end
        checks++; if (ext_write_strobe !== 4'b1000) begin errors++; $display("FAIL sb_strobe: got %b expected 1000", ext_write_strobe); end
        checks++; if (ext_write_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", ext_write_data); end
        next_cycle();
        ext_ready = 1'b0; stall = 1'b0;
        #1;
        if (mem_busy) busy_cnt++;
        checks++; if (ext_write !== 1'b0) begin errors++; $display("FAIL sb_write_drop: got %b expected 0", ext_write); end
        next_cycle();
        mem_store = 1'b0;
        #1;
        if (mem_busy) busy_cnt++;
        checks++; if (busy_cnt !== 2) begin errors++; $display("FAIL sb_busy_cycles: got %0d expected 2", busy_cnt); end
    endtask

    task automatic test_half_load(input logic sgn, input logic [31:0] expected);
        int busy_cnt = 0;
        mem_load = 1'b1; mem_address = 32'h0000_2002; mem_size = 2'd1; mem_signed = sgn; stall = 1'b1;
        #1; if (mem_busy) busy_cnt++;
        next_cycle();
        ext_ready = 1'b1;
        #1; if (mem_busy) busy_cnt++;
        checks++; if (ext_read !== 1'b1) begin errors++; $display("FAIL hl_read: got %b expected 1", ext_read); end
        checks++; if (ext_address !== 32'h0000_2000) begin errors++; $display("FAIL hl_addr: got %h expected 00002000", ext_address); end
        next_cycle();
        ext_ready = 1'b0;
        #1; if (mem_busy) busy_cnt++;
        checks++; if (ext_read !== 1'b0) begin errors++; $display("FAIL hl_read_drop: got %b expected 0", ext_read); end
        next_cycle();
        ext_read_valid = 1'b1; ext_read_data = 32'h8001_1234;
        #1; if (mem_busy) busy_cnt++;
        next_cycle();
        ext_read_valid = 1'b0; ext_read_data = 32'd0; stall = 1'b0;
        #1; if (mem_busy) busy_cnt++;
        checks++; if (mem_load_data !== expected) begin errors++; $display("FAIL hl_data: got %h expected %h", mem_load_data, expected); end
        checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL hl_busy_cycles: got %0d expected 4", busy_cnt); end
        next_cycle();
        mem_load = 1'b0;
    endtask

    task automatic test_wait_states();
        int busy_cnt = 0;
        mem_load = 1'b1; mem_address = 32'h0000_3004; mem_size = 2'd2; mem_signed = 1'b0; stall = 1'b1;
        #1; if (mem_busy) busy_cnt++;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            #1; if (mem_busy) busy_cnt++;
            checks++; if (ext_read !== 1'b1) begin errors++; $display("FAIL ws_read[%0d]: got %b expected 1", i, ext_read); end
            checks++; if (ext_address !== 32'h0000_3004) begin errors++; $display("FAIL ws_addr[%0d]: got %h expected 00003004", i, ext_address); end
        end
        next_cycle();
        ext_ready = 1'b1; ext_read_valid = 1'b1; ext_read_data = 32'hDEAD_BEEF;
        #1; if (mem_busy) busy_cnt++;
        next_cycle();
        ext_ready = 1'b0; ext_read_valid = 1'b0; ext_read_data = 32'd0; stall = 1'b0;
        #1; if (mem_busy) busy_cnt++;
        checks++; if (mem_load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws_data: got %h expected deadbeef", mem_load_data); end
        checks++; if (ext_read !== 1'b0) begin errors++; $display("FAIL ws_read_drop: got %b expected 0", ext_read); end
        checks++; if (busy_cnt !== 7) begin errors++; $display("FAIL ws_busy_cycles: got %0d expected 7", busy_cnt); end
        next_cycle();
        mem_load = 1'b0;
    endtask

    task automatic test_stall_in_done();
        int pulses = 0;
        mem_store = 1'b1; mem_address = 32'h0000_4008; mem_store_data = 32'h1234_5678;
        mem_size = 2'd2; stall = 1'b1;
        #1; if (ext_write) pulses++;
        next_cycle();
        ext_ready = 1'b1;
        #1; if (ext_write) pulses++;
        checks++; if (ext_write_strobe !== 4'b1111) begin errors++; $display("FAIL sd_strobe: got %b expected 1111", ext_write_strobe); end
        checks++; if (ext_write_data !== 32'h1234_5678) begin errors++; $display("FAIL sd_wdata: got %h expected 12345678", ext_write_data); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            ext_ready = 1'b0;
            #1; if (ext_write) pulses++;
            checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL sd_busy_done[%0d]: got %b expected 0", i, mem_busy); end
        end
        next_cycle();
        stall = 1'b0;
        #1; if (ext_write) pulses++;
        next_cycle();
        mem_store = 1'b0;
        #1; if (ext_write) pulses++;
        next_cycle();
        #1; if (ext_write) pulses++;
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL sd_idle_busy: got %b expected 0", mem_busy); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL sd_write_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_reset_mid_response();
        mem_load = 1'b1; mem_address = 32'h0000_5001; mem_size = 2'd0; mem_signed = 1'b0; stall = 1'b1;
        next_cycle();
        ext_ready = 1'b1;
        next_cycle();
        ext_ready = 1'b0;
        #1;
        checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL rr_busy_resp: got %b expected 1", mem_busy); end
        rst_n = 1'b0; mem_load = 1'b0; stall = 1'b0;
        next_cycle();
        rst_n = 1'b1; ext_read_valid = 1'b1; ext_read_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (ext_read !== 1'b0) begin errors++; $display("FAIL rr_read: got %b expected 0", ext_read); end
        checks++; if (mem_load_data !== 32'd0) begin errors++; $display("FAIL rr_ldata: got %h expected 0", mem_load_data); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rr_busy: got %b expected 0", mem_busy); end
        next_cycle();
        ext_read_valid = 1'b0; ext_read_data = 32'd0;
        #1;
        checks++; if (mem_load_data !== 32'd0) begin errors++; $display("FAIL rr_valid_ignored: got %h expected 0", mem_load_data); end
        checks++; if (ext_read !== 1'b0) begin errors++; $display("FAIL rr_read_later: got %b expected 0", ext_read); end
    endtask

    task automatic test_back_to_back();
        mem_load = 1'b1; mem_address = 32'h0000_6003; mem_size = 2'd0; mem_signed = 1'b1; stall = 1'b1;
        next_cycle();
        ext_ready = 1'b1; ext_read_valid = 1'b1; ext_read_data = 32'h80AA_BBCC;
        #1;
        checks++; if (ext_read !== 1'b1) begin errors++; $display("FAIL bb_read: got %b expected 1", ext_read); end
        checks++; if (ext_write_strobe !== 4'b1000) begin errors++; $display("FAIL bb_load_strobe: got %b expected 1000", ext_write_strobe); end
        next_cycle();
        ext_ready = 1'b0; ext_read_valid = 1'b0; ext_read_data = 32'd0; stall = 1'b0;
        #1;
        checks++; if (mem_load_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL bb_load_data: got %h expected ffffff80", mem_load_data); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL bb_done_busy: got %b expected 0", mem_busy); end
        next_cycle();
        mem_load = 1'b0; mem_store = 1'b1; mem_address = 32'h0000_6006;
        mem_store_data = 32'h0000_BEEF; mem_size = 2'd1; mem_signed = 1'b0; stall = 1'b1;
        #1;
        checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL bb_store_busy: got %b expected 1", mem_busy); end
        checks++; if (ext_write !== 1'b0) begin errors++; $display("FAIL bb_write_early: got %b expected 0", ext_write); end
        next_cycle();
        ext_ready = 1'b1;
        #1;
        checks++; if (ext_write !== 1'b1 || ext_read !== 1'b0) begin errors++; $display("FAIL bb_dir: got write=%b read=%b expected write=1 read=0", ext_write, ext_read); end
        checks++; if (ext_address !== 32'h0000_6004) begin errors++; $display("FAIL bb_addr: got %h expected 00006004", ext_address); end
        checks++; if (ext_write_strobe !== 4'b1100) begin errors++; $display("FAIL bb_store_strobe: got %b expected 1100", ext_write_strobe); end
        checks++; if (ext_write_data !== 32'hBEEF_BEEF) begin errors++; $display("FAIL bb_wdata: got %h expected beefbeef", ext_write_data); end
        next_cycle();
        ext_ready = 1'b0; stall = 1'b0;
        #1;
        checks++; if (mem_busy !== 1'b0 || ext_write !== 1'b0) begin errors++; $display("FAIL bb_store_done: got busy=%b write=%b expected 0 0", mem_busy, ext_write); end
        next_cycle();
        mem_store = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_half_load(1'b1, 32'hFFFF_8001);
        test_half_load(1'b0, 32'h0000_8001);
        test_wait_states();
        test_stall_in_done();
        test_reset_mid_response();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_adapter.md
# data_bus_adapter

Responder for the memory stage's load/store request port; sits between the pipeline and the external 32-bit data bus. It accepts byte/half/word requests, drives word-aligned bus transactions with byte strobes, and holds the pipeline stalled until each transaction completes. It returns load data already shifted and sign/zero-extended, ready for the memory stage to capture on the edge where the stall drops.

## Interface
- Parameters: none.
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous reset, active low
- mem_address  input  32  byte address from memory stage
- mem_store_data  input  32  store data, right-aligned
- mem_size  input  2  0=byte, 1=half, 2=word, 3 treated as word
- mem_signed  input  1  sign-extend loads
- mem_load  input  1  load request (level, held while stalled)
- mem_store  input  1  store request (level, held while stalled)
- mem_load_data  output  32  extended load result
- mem_busy  output  1  to hazard unit; forces pipeline stall
- stall  input  1  global stall from hazard unit (includes mem_busy)
- ext_address  output  32  word address, bits [1:0]=0
- ext_write_data  output  32  lane-replicated store data
- ext_write_strobe  output  4  byte enables
- ext_read  output  1  read request
- ext_write  output  1  write request
- ext_ready  input  1  request accepted this cycle
- ext_read_data  input  32  raw read word
- ext_read_valid  input  1  read data valid this cycle

## Operation
- States: IDLE, REQUEST, RESPONSE, DONE.
- IDLE: mem_load or mem_store high -> latch address, data, size, signed, direction; go REQUEST. Load wins if both high (must not occur).
- REQUEST: ext_read/ext_write asserted from latched direction, address/strobe/data held stable. On ext_ready: store -> DONE; load -> RESPONSE, or DONE directly if ext_read_valid also high that cycle (data captured).
- RESPONSE: wait ext_read_valid; capture extended data into result register; -> DONE.
- DONE: mem_busy low; mem_load_data = result register. Leave to IDLE only when stall is low (pipeline advances this edge); stay in DONE while stall high, so a held request is never reissued.
- mem_busy = (IDLE and (mem_load or mem_store)) or REQUEST or RESPONSE. Never high in DONE.
- Strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Write data: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- Load: shift ext_read_data right by 8*addr[1:0]; byte/half take low 8/16 bits; extend with top bit if signed, else zeros. Word unmodified.
- Misaligned addresses are filtered upstream; adapter uses addr[0] only for byte lane select.
- Once a bus request is issued it completes; pipeline invalidation does not abort it.

## Timing
- Reset (rst_n low at edge): state IDLE, ext_read=0, ext_write=0, ext_write_strobe=0, ext_address=0, ext_write_data=0, mem_load_data=0. Reset mid-transaction abandons it; bus outputs low next cycle.
- Request seen in IDLE cycle N: mem_busy high combinationally in N; ext_read/ext_write high from N+1.
- Store, zero-wait bus (ext_ready in N+1): DONE in N+2, pipeline advances at end of N+2; 2 stall cycles.
- Load, ready and valid both in N+1: data in mem_load_data during N+2; 2 stall cycles. Each extra wait cycle adds one.
- ext_read/ext_write drop the cycle after ext_ready.
- ext_read_valid outside RESPONSE/accepted-REQUEST is ignored.
- No combinational path from stall to mem_busy.

## Test plan
- Store byte 0xA5 at 0x1003, zero-wait -> ext_address=0x1000, strobe=4'b1000, data=0xA5A5A5A5, ext_write one cycle, mem_busy high 2 cycles.
- Signed half load at 0x2002, word 0x8001_1234, ready N+1, valid N+3 -> mem_load_data=0xFFFF8001; unsigned -> 0x00008001; mem_busy high 4 cycles.
- Word load with ext_ready held low 5 cycles -> ext_read, address stable throughout; mem_busy high until data; result matches word.
- Store completes while external stall held 3 cycles in DONE -> exactly one ext_write pulse, no reissue, IDLE after stall drops.
- rst_n low during RESPONSE -> next cycle IDLE, ext_read=0, mem_load_data=0; later ext_read_valid ignored.
- Back-to-back load then store -> two separate transactions, DONE between them, correct strobes each.
